fifo_rd_packer: RTL and testbench

- Read-side consumer of the dual-clock FIFO. Runs entirely in the FIFO read clock domain.
- Drives the FIFO pop strobe and absorbs the one-cycle registered RAM read latency.
- Packs RATIO consecutive FIFO words into one wide word and presents it on a valid/ready stream through a 2-entry output queue.
- A flush request emits a partially filled word with a lane-keep mask.

---
 rtl/fifo_rd_packer.sv | 139 +++++++++++++
 tb/tb_fifo_rd_packer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - read-side FIFO consumer packing RATIO words per output beat
// Pops the dual-clock FIFO, absorbs its one-cycle read latency, and queues packed words (2 deep).
module fifo_rd_packer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                     rclk,
    input  logic                     rrst,
    input  logic                     rempty,
    input  logic [WIDTH-1:0]         rdata,
    output logic                     rinc,
    input  logic                     flush,
    output logic                     flush_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RATIO*WIDTH-1:0]   out_data,
    output logic [RATIO-1:0]         out_keep
);

    localparam int CW = $clog2(RATIO) + 1;
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    typedef enum logic [1:0] {RUN, DRAIN, EMIT} state_t;

    state_t                   state;
    logic [CW-1:0]            pack_cnt;
    logic                     pend;
    logic [RATIO*WIDTH-1:0]   asm_data;
    logic [RATIO*WIDTH-1:0]   q_data [2];
    logic [RATIO-1:0]         q_keep [2];
    logic                     q_rd;
    logic                     q_wr;
    logic [1:0]               out_cnt;

    logic                     q_pop;
    logic                     complete;
    logic                     emit_push;
    logic                     push;
    logic [1:0]               base_cnt;
    logic [1:0]               out_cnt_next;
    logic [CW-1:0]            pack_cnt_next;
    logic [RATIO*WIDTH-1:0]   asm_next;
    logic [RATIO*WIDTH-1:0]   part_data;
    logic [RATIO-1:0]         part_keep;
    logic [RATIO*WIDTH-1:0]   push_data;
    logic [RATIO-1:0]         push_keep;

    always_comb begin
        asm_next  = asm_data;
        part_data = '0;
        part_keep = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (pend && pack_cnt == CW'(i))
                asm_next[i*WIDTH +: WIDTH] = rdata;
            part_keep[i] = (CW'(i) < pack_cnt);
            if (CW'(i) < pack_cnt)
                part_data[i*WIDTH +: WIDTH] = asm_data[i*WIDTH +: WIDTH];
        end
    end

    // Room is judged against the queue level after this edge's pop, so a
    // pop and a push in the same cycle never overflow the 2-entry queue.
    always_comb begin
        q_pop        = (out_cnt != 2'd0) && out_ready;
        complete     = pend && (pack_cnt == LAST);
        base_cnt     = out_cnt - {1'b0, q_pop};
        emit_push    = (state == EMIT) && (base_cnt < 2'd2);
        push         = complete || emit_push;
        out_cnt_next = base_cnt + {1'b0, push};
        if (push)
            pack_cnt_next = '0;
        else if (pend)
            pack_cnt_next = pack_cnt + CW'(1);
        else
            pack_cnt_next = pack_cnt;
        push_data    = complete ? asm_next : part_data;
        push_keep    = complete ? {RATIO{1'b1}} : part_keep;
        rinc         = !rrst && !rempty && (state == RUN) &&
                       ((pack_cnt_next < LAST) || (out_cnt_next < 2'd2));
    end

    assign out_valid = (out_cnt != 2'd0);
    assign out_data  = q_data[q_rd];
    assign out_keep  = q_keep[q_rd];

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state      <= RUN;
            pack_cnt   <= '0;
            pend       <= 1'b0;
            asm_data   <= '0;
            q_data[0]  <= '0;
            q_data[1]  <= '0;
            q_keep[0]  <= '0;
            q_keep[1]  <= '0;
            q_rd       <= 1'b0;
            q_wr       <= 1'b0;
            out_cnt    <= 2'd0;
            flush_done <= 1'b0;
        end else begin
            pend       <= rinc;
            pack_cnt   <= pack_cnt_next;
            asm_data   <= push ? '0 : asm_next;
            out_cnt    <= out_cnt_next;
            flush_done <= 1'b0;
            if (push) begin
                q_data[q_wr] <= push_data;
                q_keep[q_wr] <= push_keep;
                q_wr         <= ~q_wr;
            end
            if (q_pop)
                q_rd <= ~q_rd;
            case (state)
                RUN: begin
                    if (flush)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (!pend) begin
                        if (pack_cnt == '0) begin
                            state      <= RUN;
                            flush_done <= 1'b1;
                        end else begin
                            state <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (emit_push) begin
                        state      <= RUN;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - directed bench for fifo_rd_packer (RATIO=4 and RATIO=1)
module tb_fifo_rd_packer;

    logic        rclk;
    logic        rrst;

    logic        rempty_a, rinc_a, flush_a, flush_done_a, out_valid_a, out_ready_a;
    logic [7:0]  rdata_a;
    logic [31:0] out_data_a;
    logic [3:0]  out_keep_a;

    logic        rempty_b, rinc_b, flush_b, flush_done_b, out_valid_b, out_ready_b;
    logic [7:0]  rdata_b;
    logic [7:0]  out_data_b;
    logic [0:0]  out_keep_b;

    fifo_rd_packer #(.WIDTH(8), .RATIO(4)) u_dut_a (
        .rclk(rclk), .rrst(rrst), .rempty(rempty_a), .rdata(rdata_a), .rinc(rinc_a),
        .flush(flush_a), .flush_done(flush_done_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_data(out_data_a), .out_keep(out_keep_a)
    );

    fifo_rd_packer #(.WIDTH(8), .RATIO(1)) u_dut_b (
        .rclk(rclk), .rrst(rrst), .rempty(rempty_b), .rdata(rdata_b), .rinc(rinc_b),
        .flush(flush_b), .flush_done(flush_done_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_data(out_data_b), .out_keep(out_keep_b)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    logic [7:0] mem_a [64];
    logic [7:0] mem_b [64];
    int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;

    assign rempty_a = (rd_a == wr_a);
    assign rempty_b = (rd_b == wr_b);

    always @(posedge rclk) begin
        if (rinc_a && !rempty_a) begin
            rdata_a <= mem_a[rd_a % 64];
            rd_a    <= rd_a + 1;
        end
        if (rinc_b && !rempty_b) begin
            rdata_b <= mem_b[rd_b % 64];
            rd_b    <= rd_b + 1;
        end
    end

    logic [35:0] got_a [$];
    logic [8:0]  got_b [$];

    always @(negedge rclk) begin
        if (!rrst && out_valid_a && out_ready_a) got_a.push_back({out_keep_a, out_data_a});
        if (!rrst && out_valid_b && out_ready_b) got_b.push_back({out_keep_b, out_data_b});
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] w);
        mem_a[wr_a % 64] = w;
        wr_a++;
        #1;
    endtask

    task automatic push_b(input logic [7:0] w);
        mem_b[wr_b % 64] = w;
        wr_b++;
        #1;
    endtask

    int fd_n;
    int pops0;
    int cnt_v;
    int cnt_r;

    initial begin
        rrst = 1'b1;
        flush_a = 1'b0;
        flush_b = 1'b0;
        out_ready_a = 1'b1;
        out_ready_b = 1'b1;

        // Test 1: reset values with data waiting, then one full packed word
        push_a(8'h11); push_a(8'h22); push_a(8'h33); push_a(8'h44);
        tick(); tick();
        chk("rst_rinc", 64'(rinc_a), 64'd0);
        chk("rst_valid", 64'(out_valid_a), 64'd0);
        chk("rst_data", 64'(out_data_a), 64'd0);
        chk("rst_keep", 64'(out_keep_a), 64'd0);
        chk("rst_fd", 64'(flush_done_a), 64'd0);
        rrst = 1'b0;
        #1;
        chk("t1_rinc_on", 64'(rinc_a), 64'd1);
        repeat (4) tick();
        chk("t1_lat_early", 64'(out_valid_a), 64'd0);
        tick();
        chk("t1_valid", 64'(out_valid_a), 64'd1);
        chk("t1_data", 64'(out_data_a), 64'h44332211);
        chk("t1_keep", 64'(out_keep_a), 64'hF);
        chk("t1_pops", 64'(rd_a), 64'd4);
        tick();
        chk("t1_once", 64'(out_valid_a), 64'd0);
        chk("t1_rinc_off", 64'(rinc_a), 64'd0);

        // Test 2: back-pressure stalls popping with data still in the FIFO
        out_ready_a = 1'b0;
        got_a.delete();
        for (int i = 1; i <= 12; i++) push_a(8'(i));
        repeat (20) tick();
        chk("t2_stall_rinc", 64'(rinc_a), 64'd0);
        chk("t2_not_empty", 64'(rempty_a), 64'd0);
        chk("t2_valid", 64'(out_valid_a), 64'd1);
        chk("t2_head", 64'(out_data_a), 64'h04030201);
        out_ready_a = 1'b1;
        repeat (20) tick();
        chk("t2_count", 64'(got_a.size()), 64'd3);
        if (got_a.size() == 3) begin
            chk("t2_w0", 64'(got_a[0]), 64'hF_04030201);
            chk("t2_w1", 64'(got_a[1]), 64'hF_08070605);
            chk("t2_w2", 64'(got_a[2]), 64'hF_0C0B0A09);
        end
        chk("t2_drained", 64'(rempty_a), 64'd1);

        // Test 3: flush of a two-lane partial word, then a clean full word
        got_a.delete();
        push_a(8'hA1); push_a(8'hB2);
        repeat (6) tick();
        chk("t3_no_out", 64'(out_valid_a), 64'd0);
        fd_n = 0;
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        if (flush_done_a) fd_n++;
        repeat (9) begin
            tick();
            if (flush_done_a) fd_n++;
        end
        chk("t3_fd_pulse", 64'(fd_n), 64'd1);
        chk("t3_count", 64'(got_a.size()), 64'd1);
        if (got_a.size() == 1) chk("t3_partial", 64'(got_a[0]), 64'h3_0000B2A1);
        got_a.delete();
        push_a(8'hC1); push_a(8'hC2); push_a(8'hC3); push_a(8'hC4);
        repeat (10) tick();
        chk("t3_next_cnt", 64'(got_a.size()), 64'd1);
        if (got_a.size() == 1) chk("t3_next_word", 64'(got_a[0]), 64'hF_C4C3C2C1);

        // Test 4: flush coincides with the pop of the fourth lane
        got_a.delete();
        push_a(8'hD1); push_a(8'hD2); push_a(8'hD3);
        repeat (8) tick();
        push_a(8'hD4);
        chk("t4_rinc", 64'(rinc_a), 64'd1);
        fd_n = 0;
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        if (flush_done_a) fd_n++;
        repeat (9) begin
            tick();
            if (flush_done_a) fd_n++;
        end
        chk("t4_fd_pulse", 64'(fd_n), 64'd1);
        chk("t4_count", 64'(got_a.size()), 64'd1);
        if (got_a.size() == 1) chk("t4_full", 64'(got_a[0]), 64'hF_D4D3D2D1);

        // Test 6: reset with three lanes filled and a pop in flight
        got_a.delete();
        push_a(8'hE1); push_a(8'hE2); push_a(8'hE3);
        repeat (8) tick();
        push_a(8'hE4);
        tick();
        rrst = 1'b1;
        tick();
        chk("t6_valid", 64'(out_valid_a), 64'd0);
        chk("t6_rinc", 64'(rinc_a), 64'd0);
        chk("t6_keep", 64'(out_keep_a), 64'd0);
        pops0 = rd_a;
        rrst = 1'b0;
        push_a(8'hF1); push_a(8'hF2); push_a(8'hF3); push_a(8'hF4);
        repeat (10) tick();
        chk("t6_no_reread", 64'(rd_a - pops0), 64'd4);
        chk("t6_count", 64'(got_a.size()), 64'd1);
        if (got_a.size() == 1) chk("t6_clean", 64'(got_a[0]), 64'hF_F4F3F2F1);

        // Test 5: RATIO=1 streams one word per cycle
        got_b.delete();
        for (int i = 0; i < 8; i++) push_b(8'h70 + 8'(i));
        cnt_v = 0;
        cnt_r = 0;
        if (rinc_b) cnt_r++;
        repeat (12) begin
            tick();
            if (rinc_b) cnt_r++;
            if (out_valid_b) cnt_v++;
        end
        chk("t5_rinc_cycles", 64'(cnt_r), 64'd8);
        chk("t5_valid_cycles", 64'(cnt_v), 64'd8);
        chk("t5_count", 64'(got_b.size()), 64'd8);
        if (got_b.size() == 8) begin
            for (int i = 0; i < 8; i++)
                chk($sformatf("t5_w%0d", i), 64'(got_b[i]), 64'({1'b1, 8'h70 + 8'(i)}));
        end
        chk("t5_fd_idle", 64'(flush_done_b), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
